nlc_horner_sequencer: RTL and testbench

- Time-multiplexes one shared smc_float multiplier, one smc_float adder and both format converters across NUM_CH ADC channels.
- Per channel, computes t = (x + neg_mean) * recip_stdev, then the Horner polynomial y = ((((c5·t+c4)·t+c3)·t+c2)·t+c1)·t+c0.
- Sits between the per-channel coefficient/x_adc muxes and the x_lin output register bank in the NLC top level.
- Drives the channel/coefficient selects and all unit handshakes.

---
 rtl/nlc_pkg.sv | 23 ++
 rtl/nlc_horner_sequencer_if.sv | 58 +++++
 rtl/nlc_op_watchdog.sv | 39 +++
 rtl/nlc_horner_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_nlc_horner_sequencer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nlc_pkg.sv
// Shared types and constants for the NLC Horner sequencer.
// Holds the sequencer state enum and the datapath word widths.
package nlc_pkg;

    localparam int unsigned SMC_W      = 32;  // smc_float word width
    localparam int unsigned FP_W       = 21;  // fixed-point result width
    localparam int unsigned COEFF_TOP  = 5;   // highest polynomial coefficient index
    localparam int unsigned COEFF_W    = 3;   // coefficient select width
    localparam int unsigned OPS_PER_CH = 14;  // arithmetic/convert ops per channel

    typedef enum logic [3:0] {
        S_IDLE,
        S_CONV_IN,
        S_NORM_ADD,
        S_NORM_MUL,
        S_H_MUL,
        S_H_ADD,
        S_CONV_OUT,
        S_WRITE,
        S_DONE
    } nlc_state_t;

endpackage

// File: rtl/nlc_horner_sequencer_if.sv
// Bundle of all sequencer-facing signals: start/done handshake, channel and
// coefficient selects with their muxed operands, the four shared-unit
// handshakes (cin, mul, add, cout) and the x_lin write port.
// master: the sequencer side. slave: the surrounding NLC top level.
interface nlc_horner_sequencer_if #(
    parameter int unsigned NUM_CH = 16
);
    import nlc_pkg::*;

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic               srdyi;
    logic               srdyo;
    logic               busy;
    logic               overrun;
    logic [CH_W-1:0]    ch_sel;
    logic [COEFF_W-1:0] coeff_sel;
    logic [SMC_W-1:0]   sel_neg_mean;
    logic [SMC_W-1:0]   sel_recip_stdev;
    logic [SMC_W-1:0]   sel_coeff;
    logic               cin_srdyi;
    logic               cin_srdyo;
    logic [SMC_W-1:0]   cin_y;
    logic [SMC_W-1:0]   mul_x;
    logic [SMC_W-1:0]   mul_y;
    logic               mul_srdyi;
    logic               mul_srdyo;
    logic [SMC_W-1:0]   mul_z;
    logic [SMC_W-1:0]   add_x;
    logic [SMC_W-1:0]   add_y;
    logic               add_srdyi;
    logic               add_srdyo;
    logic [SMC_W-1:0]   add_z;
    logic [SMC_W-1:0]   cout_x;
    logic               cout_srdyi;
    logic               cout_srdyo;
    logic [FP_W-1:0]    cout_y;
    logic               lin_we;
    logic [CH_W-1:0]    lin_ch;
    logic [FP_W-1:0]    lin_data;

    modport master (
        input  srdyi, sel_neg_mean, sel_recip_stdev, sel_coeff,
        input  cin_srdyo, cin_y, mul_srdyo, mul_z, add_srdyo, add_z, cout_srdyo, cout_y,
        output srdyo, busy, overrun, ch_sel, coeff_sel,
        output cin_srdyi, mul_x, mul_y, mul_srdyi, add_x, add_y, add_srdyi,
        output cout_x, cout_srdyi, lin_we, lin_ch, lin_data
    );

    modport slave (
        output srdyi, sel_neg_mean, sel_recip_stdev, sel_coeff,
        output cin_srdyo, cin_y, mul_srdyo, mul_z, add_srdyo, add_z, cout_srdyo, cout_y,
        input  srdyo, busy, overrun, ch_sel, coeff_sel,
        input  cin_srdyi, mul_x, mul_y, mul_srdyi, add_x, add_y, add_srdyi,
        input  cout_x, cout_srdyi, lin_we, lin_ch, lin_data
    );

endinterface

// File: rtl/nlc_op_watchdog.sv
// Per-op wait counter for the Horner sequencer (built only with
// NLC_SEQ_TIMEOUT_EN). Restarts on every unit start strobe and raises a
// one-cycle registered expired pulse when the awaited done has not arrived
// TIMEOUT cycles after the strobe.
// Ports: clk, rst_n; active (sequencer is in an op state), start (any unit
// start strobe), done (awaited done accepted this cycle); expired (pulse).
`ifdef NLC_SEQ_TIMEOUT_EN
module nlc_op_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic start,
    input  logic done,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    // cnt equals the number of cycles elapsed since the strobe; saturates at TIMEOUT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else begin
            expired <= active && !start && !done && (cnt == CNT_W'(TIMEOUT - 1));
            if (start) begin
                cnt <= CNT_W'(1);
            end else if (active && (cnt != CNT_W'(TIMEOUT))) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule
`endif

// File: rtl/nlc_horner_sequencer.sv
// Horner sequencer: time-multiplexes one multiplier, one adder and the two
// format converters across NUM_CH channels, computing
// t = (x + neg_mean) * recip_stdev and y = c5 t^5 + ... + c0 per channel,
// then writing y into the x_lin bank.
// Ports: clk, rst_n; bus (master): srdyi/srdyo/busy/overrun handshake,
// ch_sel/coeff_sel with muxed operands, cin/mul/add/cout unit handshakes,
// lin_we/lin_ch/lin_data write port.
// Optional: NLC_SEQ_TIMEOUT_EN adds TIMEOUT, a per-op watchdog and the
// err_timeout pulse output; a timed-out channel is dropped and the run ends.
module nlc_horner_sequencer
    import nlc_pkg::*;
#(
    parameter int unsigned NUM_CH = 16
`ifdef NLC_SEQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 255
`endif
) (
    input  logic clk,
    input  logic rst_n,
`ifdef NLC_SEQ_TIMEOUT_EN
    output logic err_timeout,
`endif
    nlc_horner_sequencer_if.master bus
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    nlc_state_t         state_q, state_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [COEFF_W-1:0] k_q, k_d, coeff_d;
    logic [SMC_W-1:0]   x_q, x_d, tmp_q, tmp_d, t_q, t_d, acc_q, acc_d;
    logic [SMC_W-1:0]   mul_x_d, mul_y_d, add_x_d, add_y_d, cout_x_d;
    logic [FP_W-1:0]    lin_data_d;
    logic               overrun_d, op_done, enter;

    assign bus.ch_sel = ch_q;
    assign bus.lin_ch = ch_q;

`ifdef NLC_SEQ_TIMEOUT_EN
    logic op_active, wd_expired;

    assign op_active = state_q inside {S_CONV_IN, S_NORM_ADD, S_NORM_MUL,
                                       S_H_MUL, S_H_ADD, S_CONV_OUT};
    assign err_timeout = wd_expired;

    nlc_op_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .active  (op_active),
        .start   (bus.cin_srdyi | bus.add_srdyi | bus.mul_srdyi | bus.cout_srdyi),
        .done    (op_done),
        .expired (wd_expired)
    );
`endif

    // Next-state, datapath capture and operand/select loads
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        k_d        = k_q;
        x_d        = x_q;
        tmp_d      = tmp_q;
        t_d        = t_q;
        acc_d      = acc_q;
        coeff_d    = bus.coeff_sel;
        mul_x_d    = bus.mul_x;
        mul_y_d    = bus.mul_y;
        add_x_d    = bus.add_x;
        add_y_d    = bus.add_y;
        cout_x_d   = bus.cout_x;
        lin_data_d = bus.lin_data;
        overrun_d  = bus.overrun;
        op_done    = 1'b0;
        enter      = 1'b0;

        // A done arriving in the strobe cycle cannot belong to this op
        case (state_q)
            S_IDLE: begin
                if (bus.srdyi) begin
                    ch_d      = '0;
                    overrun_d = 1'b0;
                    state_d   = S_CONV_IN;
                end
            end
            S_CONV_IN: begin
                op_done = bus.cin_srdyo && !bus.cin_srdyi;
                if (op_done) begin
                    x_d     = bus.cin_y;
                    state_d = S_NORM_ADD;
                end
            end
            S_NORM_ADD: begin
                op_done = bus.add_srdyo && !bus.add_srdyi;
                if (op_done) begin
                    tmp_d   = bus.add_z;
                    state_d = S_NORM_MUL;
                end
            end
            S_NORM_MUL: begin
                op_done = bus.mul_srdyo && !bus.mul_srdyi;
                if (op_done) begin
                    t_d     = bus.mul_z;
                    acc_d   = bus.sel_coeff;
                    k_d     = COEFF_W'(COEFF_TOP - 1);
                    state_d = S_H_MUL;
                end
            end
            S_H_MUL: begin
                op_done = bus.mul_srdyo && !bus.mul_srdyi;
                if (op_done) begin
                    tmp_d   = bus.mul_z;
                    state_d = S_H_ADD;
                end
            end
            S_H_ADD: begin
                op_done = bus.add_srdyo && !bus.add_srdyi;
                if (op_done) begin
                    acc_d = bus.add_z;
                    if (k_q != '0) begin
                        k_d     = k_q - COEFF_W'(1);
                        state_d = S_H_MUL;
                    end else begin
                        state_d = S_CONV_OUT;
                    end
                end
            end
            S_CONV_OUT: begin
                op_done = bus.cout_srdyo && !bus.cout_srdyi;
                if (op_done) begin
                    lin_data_d = bus.cout_y;
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                if (ch_q == LAST_CH) begin
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = S_CONV_IN;
                end
            end
            S_DONE: begin
                ch_d    = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_q != S_IDLE) && bus.srdyi) begin
            overrun_d = 1'b1;
        end

`ifdef NLC_SEQ_TIMEOUT_EN
        if (op_active && wd_expired) begin
            state_d = S_DONE;
        end
`endif

        // Operands and selects are loaded on state entry and held for the op;
        // coeff_sel leads by one state so sel_coeff is ready when H_ADD loads
        enter = (state_d != state_q);
        if (enter) begin
            case (state_d)
                S_NORM_ADD: begin
                    add_x_d = x_d;
                    add_y_d = bus.sel_neg_mean;
                end
                S_NORM_MUL: begin
                    mul_x_d = tmp_d;
                    mul_y_d = bus.sel_recip_stdev;
                    coeff_d = COEFF_W'(COEFF_TOP);
                end
                S_H_MUL: begin
                    mul_x_d = acc_d;
                    mul_y_d = t_d;
                    coeff_d = k_d;
                end
                S_H_ADD: begin
                    add_x_d = tmp_d;
                    add_y_d = bus.sel_coeff;
                end
                S_CONV_OUT: cout_x_d = acc_d;
                S_IDLE:     coeff_d  = '0;
                default:    ;
            endcase
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            ch_q           <= '0;
            k_q            <= '0;
            x_q            <= '0;
            tmp_q          <= '0;
            t_q            <= '0;
            acc_q          <= '0;
            bus.srdyo      <= 1'b0;
            bus.busy       <= 1'b0;
            bus.overrun    <= 1'b0;
            bus.coeff_sel  <= '0;
            bus.cin_srdyi  <= 1'b0;
            bus.mul_srdyi  <= 1'b0;
            bus.add_srdyi  <= 1'b0;
            bus.cout_srdyi <= 1'b0;
            bus.mul_x      <= '0;
            bus.mul_y      <= '0;
            bus.add_x      <= '0;
            bus.add_y      <= '0;
            bus.cout_x     <= '0;
            bus.lin_we     <= 1'b0;
            bus.lin_data   <= '0;
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            k_q            <= k_d;
            x_q            <= x_d;
            tmp_q          <= tmp_d;
            t_q            <= t_d;
            acc_q          <= acc_d;
            bus.srdyo      <= (state_d == S_DONE);
            bus.busy       <= (state_d != S_IDLE);
            bus.overrun    <= overrun_d;
            bus.coeff_sel  <= coeff_d;
            bus.cin_srdyi  <= enter && (state_d == S_CONV_IN);
            bus.mul_srdyi  <= enter && (state_d inside {S_NORM_MUL, S_H_MUL});
            bus.add_srdyi  <= enter && (state_d inside {S_NORM_ADD, S_H_ADD});
            bus.cout_srdyi <= enter && (state_d == S_CONV_OUT);
            bus.mul_x      <= mul_x_d;
            bus.mul_y      <= mul_y_d;
            bus.add_x      <= add_x_d;
            bus.add_y      <= add_y_d;
            bus.cout_x     <= cout_x_d;
            bus.lin_we     <= (state_d == S_WRITE);
            bus.lin_data   <= lin_data_d;
        end
    end

endmodule

// File: tb/tb_nlc_horner_sequencer.sv
// Self-checking bench for nlc_horner_sequencer: integer stub units with
// programmable latency, random per-channel operands, and a reference model
// that evaluates the normalisation and polynomial directly per channel.
module tb_nlc_horner_sequencer;
    import nlc_pkg::*;

    localparam int unsigned NUM_CH = 16;
    localparam int unsigned CH_W   = 4;

    typedef struct {
        int          kind;   // 0 cin, 1 add, 2 mul, 3 cout
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    typedef struct {
        int          ch;
        logic [20:0] data;
        int          at;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          n_err = 0;
    int          n_chk = 0;
    int          cyc = 0;
    int          t0 = 0;
    logic [31:0] x_adc [NUM_CH];
    logic [31:0] nm    [NUM_CH];
    logic [31:0] rs    [NUM_CH];
    logic [31:0] cf    [NUM_CH][6];
    op_t         exp_ops[$];
    wr_t         exp_w[$];
    bit          mon_ops = 1'b0;
    int          mul_l = 1, add_l = 1, conv_l = 1;
    int          mul_cnt, add_cnt, cin_cnt, cout_cnt;
    logic [31:0] mul_res, add_res, cin_res;
    logic [20:0] cout_res;
    bit          mul_force = 1'b0;
    bit          hold_add = 1'b0;
    int          hold_ch = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nlc_horner_sequencer_if #(.NUM_CH(NUM_CH)) bus ();

`ifdef NLC_SEQ_TIMEOUT_EN
    logic err_timeout;
    int   err_rel = -1;
    int   err_cnt = 0;
    nlc_horner_sequencer #(.NUM_CH(NUM_CH), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .err_timeout(err_timeout), .bus(bus));
`else
    nlc_horner_sequencer #(.NUM_CH(NUM_CH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    // External operand muxes
    assign bus.sel_neg_mean    = nm[bus.ch_sel];
    assign bus.sel_recip_stdev = rs[bus.ch_sel];
    assign bus.sel_coeff       = (bus.coeff_sel <= 3'd5) ? cf[bus.ch_sel][bus.coeff_sel] : 32'h0;

    // Latency-programmable integer stubs: result computed at start, done L cycles later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_cnt <= 0; add_cnt <= 0; cin_cnt <= 0; cout_cnt <= 0;
            mul_res <= '0; add_res <= '0; cin_res <= '0; cout_res <= '0;
        end else begin
            if (bus.mul_srdyi) begin
                mul_cnt <= mul_l; mul_res <= bus.mul_x * bus.mul_y;
            end else if (mul_cnt != 0) mul_cnt <= mul_cnt - 1;
            if (bus.add_srdyi) begin
                add_cnt <= add_l; add_res <= bus.add_x + bus.add_y;
            end else if (add_cnt != 0) add_cnt <= add_cnt - 1;
            if (bus.cin_srdyi) begin
                cin_cnt <= conv_l; cin_res <= x_adc[bus.ch_sel];
            end else if (cin_cnt != 0) cin_cnt <= cin_cnt - 1;
            if (bus.cout_srdyi) begin
                cout_cnt <= conv_l; cout_res <= bus.cout_x[20:0];
            end else if (cout_cnt != 0) cout_cnt <= cout_cnt - 1;
        end
    end

    assign bus.mul_srdyo  = (mul_cnt == 1) || mul_force;
    assign bus.add_srdyo  = (add_cnt == 1) && !(hold_add && (bus.ch_sel == CH_W'(hold_ch)));
    assign bus.cin_srdyo  = (cin_cnt == 1);
    assign bus.cout_srdyo = (cout_cnt == 1);
    assign bus.mul_z      = mul_res;
    assign bus.add_z      = add_res;
    assign bus.cin_y      = cin_res;
    assign bus.cout_y     = cout_res;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: per channel, the op stream and the final written value
    task automatic build(input int nwr, input int period);
        logic [31:0] s, t, acc, p;
        exp_ops.delete();
        exp_w.delete();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            s = x_adc[ch] + nm[ch];
            t = s * rs[ch];
            exp_ops.push_back('{0, 32'(ch), 32'h0});
            exp_ops.push_back('{1, x_adc[ch], nm[ch]});
            exp_ops.push_back('{2, s, rs[ch]});
            acc = cf[ch][5];
            for (int k = 4; k >= 0; k--) begin
                p = acc * t;
                exp_ops.push_back('{2, acc, t});
                exp_ops.push_back('{1, p, cf[ch][k]});
                acc = p + cf[ch][k];
            end
            exp_ops.push_back('{3, acc, 32'h0});
            if (ch < nwr) exp_w.push_back('{ch, acc[20:0], period * (ch + 1)});
        end
    endtask

    task automatic rand_data();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            x_adc[ch] = $urandom; nm[ch] = $urandom; rs[ch] = $urandom;
            for (int k = 0; k < 6; k++) cf[ch][k] = $urandom;
        end
    endtask

    // Monitor: op-stream scoreboard and x_lin write checks
    always @(negedge clk) begin
        op_t o;
        wr_t w;
        int  kind;
        logic [31:0] a, b;
        if (rst_n) begin
            if (mon_ops && (bus.cin_srdyi || bus.add_srdyi || bus.mul_srdyi || bus.cout_srdyi)) begin
                kind = bus.cin_srdyi ? 0 : bus.add_srdyi ? 1 : bus.mul_srdyi ? 2 : 3;
                a = (kind == 0) ? 32'(bus.ch_sel) : (kind == 1) ? bus.add_x : (kind == 2) ? bus.mul_x : bus.cout_x;
                b = (kind == 1) ? bus.add_y : (kind == 2) ? bus.mul_y : 32'h0;
                if (exp_ops.size() == 0) check("op_extra", 1, 0);
                else begin
                    o = exp_ops.pop_front();
                    check("op_kind", 64'(kind), 64'(o.kind));
                    check("op_a", a, o.a);
                    check("op_b", b, o.b);
                end
            end
            if (bus.lin_we) begin
                if (exp_w.size() == 0) check("w_extra", {32'(bus.lin_ch), 32'(bus.lin_data)}, 0);
                else begin
                    w = exp_w.pop_front();
                    check("w_ch", 64'(bus.lin_ch), 64'(w.ch));
                    check("w_data", 64'(bus.lin_data), 64'(w.data));
                    check("w_time", 64'(cyc - t0), 64'(w.at));
                end
            end
`ifdef NLC_SEQ_TIMEOUT_EN
            if (err_timeout) begin
                err_rel = cyc - t0;
                err_cnt++;
            end
`endif
        end
    end

    task automatic start_run();
        @(negedge clk);
        bus.srdyi = 1'b1;
        t0 = cyc;
        @(negedge clk);
        bus.srdyi = 1'b0;
    endtask

    task automatic run(input int ml, input int al, input int cl, input bit ovr,
                       input int nwr, input int exp_done);
        int period, rel;
        bit seen;
        mul_l = ml; add_l = al; conv_l = cl;
        period = (cl + 1) * 2 + (al + 1) * 6 + (ml + 1) * 6 + 1;
        build(nwr, period);
        mon_ops = (nwr == NUM_CH);
        start_run();
        check("busy_start", 64'(bus.busy), 1);
        check("ovr_clear", 64'(bus.overrun), 0);
        seen = 1'b0;
        rel = 1;
        while (!seen && rel < 3000) begin
            @(negedge clk);
            rel = cyc - t0;
            bus.srdyi = (ovr && rel == 100);
            if (bus.srdyo) seen = 1'b1;
        end
        bus.srdyi = 1'b0;
        check("srdyo_time", seen ? 64'(rel) : 64'hFFFF, 64'(exp_done));
        @(negedge clk);
        check("busy_end", 64'(bus.busy), 0);
        check("srdyo_pulse", 64'(bus.srdyo), 0);
        check("ovr_flag", 64'(bus.overrun), 64'(ovr));
        check("w_left", 64'(exp_w.size()), 0);
        if (mon_ops) check("ops_left", 64'(exp_ops.size()), 0);
        mon_ops = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [63:0] ctrl_outs();
        return 64'({bus.srdyo, bus.busy, bus.overrun, bus.ch_sel, bus.coeff_sel,
                    bus.cin_srdyi, bus.mul_srdyi, bus.add_srdyi, bus.cout_srdyi,
                    bus.lin_we, bus.lin_ch, bus.lin_data});
    endfunction

    initial begin
        bus.srdyi = 1'b0;
        rand_data();
        repeat (3) @(negedge clk);
        check("reset_ctrl", ctrl_outs(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ctrl", ctrl_outs(), 0);

        // All units L=1, random operands
        run(1, 1, 1, 1'b0, NUM_CH, 465);
        // Same data with a stray srdyi mid-run: identical outputs, overrun set
        run(1, 1, 1, 1'b1, NUM_CH, 465);
        // Mixed latencies, fresh data
        rand_data();
        run(3, 2, 1, 1'b0, NUM_CH, 753);
        // Directed integer case: t=1, acc=6 on every channel
        for (int ch = 0; ch < NUM_CH; ch++) begin
            x_adc[ch] = 32'd2; nm[ch] = 32'hFFFF_FFFF; rs[ch] = 32'd1;
            for (int k = 0; k < 6; k++) cf[ch][k] = 32'd1;
        end
        run(1, 1, 1, 1'b0, NUM_CH, 465);

        // Reset mid-run, then a stray mul done in IDLE
        rand_data();
        mul_l = 1; add_l = 1; conv_l = 1;
        build(NUM_CH, 29);
        mon_ops = 1'b1;
        start_run();
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_ctrl", ctrl_outs(), 0);
        check("midrst_oper", 64'(bus.mul_x | bus.mul_y | bus.add_x | bus.add_y | bus.cout_x), 0);
        exp_ops.delete();
        exp_w.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_ctrl", ctrl_outs(), 0);
        repeat (2) @(negedge clk);
        mul_force = 1'b1;
        @(negedge clk);
        mul_force = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_quiet", ctrl_outs(), 0);
        end
        mon_ops = 1'b0;

`ifdef NLC_SEQ_TIMEOUT_EN
        // Add done withheld on channel 3: add_srdyi at 3*29+3, err 8 later, srdyo next
        rand_data();
        hold_add = 1'b1;
        hold_ch  = 3;
        err_cnt  = 0;
        run(1, 1, 1, 1'b0, 3, 99);
        hold_add = 1'b0;
        check("err_time", 64'(err_rel), 64'(3 * 29 + 3 + 8));
        check("err_pulses", 64'(err_cnt), 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
